// File: rtl/uib_if.sv
// UIB slave bus bundle: request, write data and response signals for one
// master/slave pair. clk and rst are passed to modules as plain ports.
interface uib_if #(
  parameter int XLEN  = 32,
  parameter int LANES = 4
);
  // Handshake: a request transfers on a posedge where bus_req && bus_ready.
  // The master holds bus_req and its payload until that edge. Each accepted
  // request gets exactly one bus_ack strobe, in acceptance order. bus_dat_o
  // and bus_err are only meaningful while bus_ack is high.
  logic             bus_req;
  logic             bus_wen;
  logic [XLEN-1:0]  bus_addr;
  logic [LANES-1:0] bus_be;
  logic [XLEN-1:0]  bus_dat_i;
  logic [XLEN-1:0]  bus_dat_o;
  logic             bus_ready;
  logic             bus_ack;
  logic             bus_err;

  modport master (
    output bus_req, bus_wen, bus_addr, bus_be, bus_dat_i,
    input  bus_dat_o, bus_ready, bus_ack, bus_err
  );

  modport slave (
    input  bus_req, bus_wen, bus_addr, bus_be, bus_dat_i,
    output bus_dat_o, bus_ready, bus_ack, bus_err
  );
endinterface

// File: rtl/uib_banked_mem.sv
// UIB main-memory slave: LANES byte-lane banks with per-lane enables, pipelined
// reads (RD_LAT 1 or 2), out-of-range flagging and an optional post-reset zero-fill.
module uib_banked_mem #(
  parameter int XLEN         = 32,
  parameter int LANES        = 4,
  parameter int DEPTH_LOG2   = 10,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic       clk,
  input  logic       rst,
  uib_if.slave       bus,
  output logic       init_done,
  output logic [0:0] dbg_state
);
  localparam int W     = XLEN / LANES;
  localparam int OFF   = $clog2(LANES);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int HI    = OFF + DEPTH_LOG2;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_INIT  = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;

  if ((LANES < 1) || ((LANES & (LANES - 1)) != 0)) begin : g_bad_lanes
    $error("uib_banked_mem: LANES must be a power of two");
  end
  if ((XLEN % LANES) != 0) begin : g_bad_xlen
    $error("uib_banked_mem: XLEN must be a multiple of LANES");
  end
  if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_lat
    $error("uib_banked_mem: RD_LAT must be 1 or 2");
  end

  logic [0:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;

  logic                  s1_vld_q, s1_vld_d;
  logic                  s1_err_q, s1_err_d;
  logic [LANES-1:0]      s1_mask_q, s1_mask_d;
  logic [XLEN-1:0]       s1_dat;

  logic                  accept;
  logic                  addr_err;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [LANES-1:0]      mem_we;
  logic [XLEN-1:0]       mem_wdat;

  assign accept   = bus.bus_req & ready_q;
  assign addr_err = (bus.bus_addr >> HI) != '0;
  assign word_idx = bus.bus_addr[HI-1:OFF];

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    done_d    = done_q;
    mem_we    = '0;
    mem_idx   = word_idx;
    mem_wdat  = bus.bus_dat_i;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = {LANES{1'b1}};
        mem_idx   = clr_idx_q;
        mem_wdat  = '0;
        clr_idx_d = clr_idx_q + DEPTH_LOG2'(1);
        if (&clr_idx_q) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        ready_d = 1'b1;
        done_d  = 1'b1;
        if (accept && bus.bus_wen && !addr_err) mem_we = bus.bus_be;
      end
    endcase
    // The array is never touched while reset is held.
    if (rst) mem_we = '0;
  end

  always_comb begin
    s1_vld_d  = accept;
    s1_err_d  = accept & addr_err;
    s1_mask_d = (accept && !bus.bus_wen && !addr_err) ? bus.bus_be : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_err_q  <= 1'b0;
      s1_mask_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      s1_vld_q  <= s1_vld_d;
      s1_err_q  <= s1_err_d;
      s1_mask_q <= s1_mask_d;
    end
  end

  // Each lane is an independent bank; its read port is registered at the
  // accepting edge and the lane mask zeroes disabled, write and error lanes.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (mem_we[i]) mem[mem_idx] <= mem_wdat[i*W +: W];
      rd_q <= mem[word_idx];
    end

    assign s1_dat[i*W +: W] = s1_mask_q[i] ? rd_q : '0;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic            s2_vld_q, s2_vld_d;
    logic            s2_err_q, s2_err_d;
    logic [XLEN-1:0] s2_dat_q, s2_dat_d;

    always_comb begin
      s2_vld_d = s1_vld_q;
      s2_err_d = s1_err_q;
      s2_dat_d = s1_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_vld_q <= 1'b0;
        s2_err_q <= 1'b0;
        s2_dat_q <= '0;
      end else begin
        s2_vld_q <= s2_vld_d;
        s2_err_q <= s2_err_d;
        s2_dat_q <= s2_dat_d;
      end
    end

    assign bus.bus_ack   = s2_vld_q;
    assign bus.bus_err   = s2_err_q;
    assign bus.bus_dat_o = s2_dat_q;
  end else begin : g_lat1
    assign bus.bus_ack   = s1_vld_q;
    assign bus.bus_err   = s1_err_q;
    assign bus.bus_dat_o = s1_dat;
  end

  assign bus.bus_ready = ready_q;
  assign init_done     = done_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_uib_banked_mem.sv
// Bench for uib_banked_mem: one RD_LAT=1 and one RD_LAT=2 instance share the
// same stimulus and are checked every cycle against a word-array reference.
module tb_uib_banked_mem;
  localparam int XLEN  = 32;
  localparam int LANES = 4;
  localparam int DL    = 10;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req, wen;
  logic [31:0] addr, dati;
  logic [3:0]  be;

  uib_if #(.XLEN(XLEN), .LANES(LANES)) bus1 ();
  uib_if #(.XLEN(XLEN), .LANES(LANES)) bus2 ();

  assign bus1.bus_req   = req;
  assign bus1.bus_wen   = wen;
  assign bus1.bus_addr  = addr;
  assign bus1.bus_be    = be;
  assign bus1.bus_dat_i = dati;
  assign bus2.bus_req   = req;
  assign bus2.bus_wen   = wen;
  assign bus2.bus_addr  = addr;
  assign bus2.bus_be    = be;
  assign bus2.bus_dat_i = dati;

  logic       done1, done2;
  logic [0:0] st1, st2;

  uib_banked_mem #(.XLEN(XLEN), .LANES(LANES), .DEPTH_LOG2(DL), .RD_LAT(1), .CLEAR_ON_RST(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .init_done(done1), .dbg_state(st1)
  );
  uib_banked_mem #(.XLEN(XLEN), .LANES(LANES), .DEPTH_LOG2(DL), .RD_LAT(2), .CLEAR_ON_RST(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .init_done(done2), .dbg_state(st2)
  );

  typedef struct {
    int          due;
    logic [31:0] dat;
    logic        err;
  } resp_t;

  resp_t       q1[$];
  resp_t       q2[$];
  logic [31:0] ref_mem [DEPTH];
  int          cyc;
  int          clr_edges;
  bit          exp_ready;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference behaviour at one rising edge, using the inputs held before it.
  task automatic model_edge();
    resp_t       r;
    logic [31:0] d;
    logic        e;
    int          word;
    cyc++;
    if (rst) return;
    if (exp_ready && req) begin
      e    = addr >= 32'(LANES * DEPTH);
      word = int'(addr / LANES);
      d    = '0;
      if (!e) begin
        for (int l = 0; l < LANES; l++) begin
          if (be[l]) begin
            if (wen) ref_mem[word][l*8 +: 8] = dati[l*8 +: 8];
            else     d[l*8 +: 8] = ref_mem[word][l*8 +: 8];
          end
        end
      end
      r.dat = d;
      r.err = e;
      // Ack is sampled RD_LAT edges after acceptance, so it is visible from
      // edge (accept + RD_LAT - 1) onward for one cycle.
      r.due = cyc;
      q1.push_back(r);
      r.due = cyc + 1;
      q2.push_back(r);
    end
    if (!exp_ready) begin
      clr_edges++;
      if (clr_edges == DEPTH) begin
        exp_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
    end
  endtask

  task automatic check_dut(input int lat, input logic ack, input logic err,
                           input logic [31:0] dat, input logic rdy, input logic done);
    resp_t e;
    bit    exp_ack;
    string p;
    p       = (lat == 1) ? "lat1" : "lat2";
    exp_ack = 1'b0;
    e.due   = 0;
    e.dat   = '0;
    e.err   = 1'b0;
    if (lat == 1) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); exp_ack = 1'b1; end
    end else begin
      if (q2.size() > 0 && q2[0].due == cyc) begin e = q2.pop_front(); exp_ack = 1'b1; end
    end
    chk({p, ".ack"},   32'(ack),  32'(exp_ack));
    chk({p, ".err"},   32'(err),  32'(e.err));
    chk({p, ".dat"},   dat,       e.dat);
    chk({p, ".ready"}, 32'(rdy),  32'(exp_ready));
    chk({p, ".done"},  32'(done), 32'(exp_ready));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_dut(1, bus1.bus_ack, bus1.bus_err, bus1.bus_dat_o, bus1.bus_ready, done1);
    check_dut(2, bus2.bus_ack, bus2.bus_err, bus2.bus_dat_o, bus2.bus_ready, done2);
  endtask

  task automatic enter_reset();
    rst       = 1'b1;
    req       = 1'b0;
    q1.delete();
    q2.delete();
    exp_ready = 1'b0;
    clr_edges = 0;
  endtask

  task automatic do_reset(input int n);
    enter_reset();
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req  = 1'b1;
    wen  = w;
    addr = a;
    be   = b;
    dati = d;
    step();
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    req    = 1'b0;
    wen    = 1'b0;
    addr   = '0;
    be     = '0;
    dati   = '0;
    @(negedge clk);
    do_reset(3);

    // Write held through the whole clear; it is taken on the first RUN edge.
    req  = 1'b1;
    wen  = 1'b1;
    addr = 32'h20;
    be   = 4'hF;
    dati = 32'hCAFEF00D;
    repeat (DEPTH + 1) step();
    idle(1);
    xfer(1'b0, 32'h20,  4'hF, '0);
    xfer(1'b0, 32'h0,   4'hF, '0);
    xfer(1'b0, 32'hFFC, 4'hF, '0);
    idle(2);

    xfer(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF);
    xfer(1'b0, 32'h0,    4'hF, '0);
    xfer(1'b0, 32'h8000_0000, 4'hF, '0);
    idle(2);

    xfer(1'b1, 32'h10, 4'hF,    32'h11223344);
    xfer(1'b1, 32'h10, 4'b0101, 32'hAABBCCDD);
    xfer(1'b0, 32'h10, 4'hF,    '0);
    xfer(1'b0, 32'h13, 4'b0011, '0);
    xfer(1'b0, 32'h10, 4'h0,    '0);
    idle(2);

    xfer(1'b1, 32'h0, 4'hF, 32'd1);
    xfer(1'b1, 32'h4, 4'hF, 32'd2);
    xfer(1'b1, 32'h8, 4'hF, 32'd3);
    xfer(1'b0, 32'h0, 4'hF, '0);
    xfer(1'b0, 32'h4, 4'hF, '0);
    xfer(1'b0, 32'h8, 4'hF, '0);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      req  = ($urandom_range(0, 3) != 0);
      wen  = $urandom_range(0, 1) != 0;
      be   = 4'($urandom_range(0, 15));
      dati = $urandom;
      case ($urandom_range(0, 9))
        0:       addr = 32'h1000 + 32'($urandom_range(0, 255));
        1:       addr = 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(0, 3));
        default: addr = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
      endcase
      step();
    end
    idle(3);

    // Reset lands after a read is accepted but before its response is due.
    req  = 1'b1;
    wen  = 1'b0;
    addr = 32'h10;
    be   = 4'hF;
    @(posedge clk);
    model_edge();
    #1;
    enter_reset();
    @(negedge clk);
    check_dut(1, bus1.bus_ack, bus1.bus_err, bus1.bus_dat_o, bus1.bus_ready, done1);
    check_dut(2, bus2.bus_ack, bus2.bus_err, bus2.bus_dat_o, bus2.bus_ready, done2);
    step();
    rst = 1'b0;

    // Interrupt the clear at index 500; the full clear must restart.
    idle(500);
    do_reset(2);
    idle(DEPTH + 2);
    xfer(1'b0, 32'h10, 4'hF, '0);
    xfer(1'b0, 32'h20, 4'hF, '0);
    for (int i = 0; i < 100; i++) begin
      req  = ($urandom_range(0, 3) != 0);
      wen  = $urandom_range(0, 1) != 0;
      be   = 4'($urandom_range(0, 15));
      dati = $urandom;
      addr = 32'($urandom_range(0, 15)) * 4;
      step();
    end
    idle(3);

    chk("lat1.pending", 32'(q1.size()), 32'd0);
    chk("lat2.pending", 32'(q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uib_banked_mem.md
Name: uib_banked_mem

Overview:
Parametrised UIB slave main memory and successor to the fixed 4×8-bit-slice RAM. It splits the data word into LANES independent byte-lane banks with per-lane write enables. Reads are fully pipelined, with a configurable latency of 1 or 2 cycles and an explicit ready/ack handshake. Out-of-range accesses are flagged. An optional post-reset zero-fill state machine clears the whole array. It sits on the UIB as the main memory slave.

Parameters:
XLEN, 32, bus data/address width
LANES, 4, number of lane banks; power of two; XLEN % LANES == 0; lane width W = XLEN/LANES
DEPTH_LOG2, 10, log2 of words per lane bank
RD_LAT, 1, cycles from request acceptance to bus_ack; legal values 1 or 2
CLEAR_ON_RST, 1, 1 = zero-fill the whole array after reset before accepting requests

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
bus_req  in  1  request valid
bus_wen  in  1  1 = write, 0 = read
bus_addr  in  XLEN  byte address
bus_be  in  LANES  per-lane enable; bit i selects bits [(i+1)*W-1 : i*W]
bus_dat_i  in  XLEN  write data
bus_dat_o  out  XLEN  read data, valid while bus_ack=1
bus_ready  out  1  slave accepts a request this cycle
bus_ack  out  1  response strobe, one per accepted request
bus_err  out  1  address error, valid while bus_ack=1
init_done  out  1  clear sequence complete

Behaviour:
- Reset (async assert): bus_dat_o=0, bus_ack=0, bus_err=0, bus_ready=0, init_done=0.
  - All pipeline stages are emptied; in-flight responses are dropped.
  - FSM goes to CLEAR if CLEAR_ON_RST=1, else to RUN.
  - Reset does not modify array contents.
- FSM CLEAR:
  - A DEPTH_LOG2-bit counter starts at 0 and writes 0 to all lanes at counter index, one word per cycle.
  - After index 2^DEPTH_LOG2-1 the FSM goes to RUN. This takes exactly 2^DEPTH_LOG2 cycles after reset release.
  - bus_ready=0 throughout; bus_req is ignored and never acked.
  - Reset asserted mid-clear restarts the clear from index 0.
- FSM RUN:
  - bus_ready=1 and init_done=1, registered; both rise on the first RUN cycle.
  - RUN is terminal until reset.
- Acceptance: a request is accepted on a posedge where bus_req & bus_ready. bus_req with bus_ready=0 is lost; the master must hold it.
- Address decode:
  - Word index = bus_addr[log2(LANES)+DEPTH_LOG2-1 : log2(LANES)].
  - Bits below log2(LANES) are ignored; bus_be alone selects lanes.
  - Any set bit above the word-index field is an error.
- Write:
  - At the accepting edge, each lane i with bus_be[i]=1 stores its W-bit slice. Other lanes are unchanged.
  - Acked after RD_LAT cycles with bus_dat_o=0.
- Read:
  - Data is taken from the array at the accepting edge; RD_LAT=2 adds one output register stage.
  - Returned lanes with bus_be[i]=0 read as 0.
  - bus_be=0 gives an ack with data 0.
- Error (read or write):
  - No array write; bus_dat_o=0.
  - bus_err=1 in the same cycle as bus_ack.
- Latency: bus_ack is high exactly RD_LAT cycles after the accepting edge.
  - Back-to-back requests are accepted every cycle and acked in order, one per cycle.
  - Idle cycles give bus_ack=0, bus_err=0, bus_dat_o=0.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data.
  - Only one request per cycle exists, so there is no same-cycle conflict.
- Elaboration error if LANES is not a power of two, XLEN % LANES != 0, or RD_LAT is not 1 or 2.

Test Plan:
- CLEAR_ON_RST=1, DEPTH_LOG2=10: release rst → bus_ready/init_done rise 1024 cycles later; read 0x0 and 0xFFC with be=4'hF → 0x00000000.
- Write 0x11223344 at 0x10 with be=4'hF, then write 0xAABBCCDD at 0x10 with be=4'b0101, then read with be=4'hF → 0x11BB33DD. Read with be=4'b0011 → 0x000033DD.
- RD_LAT=2: reads at 0x0, 0x4, 0x8 on three consecutive cycles after writing 1, 2, 3 there → bus_ack high on cycles +2, +3, +4 with data 1, 2, 3 in order.
- Out-of-range write to 0x1000 with data 0xDEADBEEF → ack with bus_err=1. A following read of 0x0 is still 0 and has bus_err=0.
- Assert rst at clear index 500, release → clear restarts; bus_ready rises 1024 cycles after the release. Assert rst while a read is in flight → no bus_ack appears.
- bus_req held while bus_ready=0 during CLEAR → no ack, no array change; the request is accepted on the first RUN cycle.
